// File: rtl/midi_uart_rx_param_pkg.sv
// Shared definitions for the parametrised MIDI UART receiver: FSM encodings,
// parity mode constants and small bit-level helpers.
`ifndef F_CLK_PERIOD_NS
`define F_CLK_PERIOD_NS 100
`endif

package midi_uart_rx_param_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } rx_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int DEFAULT_CLK_PERIOD_NS = `F_CLK_PERIOD_NS;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Words are zero-extended to the widest supported payload before folding.
    function automatic logic parity9(input logic [8:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/midi_uart_rx_param_if.sv
// Receiver-to-parser word handshake: data plus error flags qualified by valid,
// back-pressured by ready.
interface midi_uart_rx_param_if #(
    parameter int PAYLOAD_BITS = 8
);
    logic [PAYLOAD_BITS-1:0] data_o;
    logic                    valid_o;
    logic                    ready_i;
    logic                    frame_err_o;
    logic                    parity_err_o;
    logic                    overrun_o;
    logic                    busy_o;

    modport master (
        output data_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o,
        input  ready_i
    );

    modport slave (
        input  data_o, valid_o, frame_err_o, parity_err_o, overrun_o, busy_o,
        output ready_i
    );
endinterface

// File: rtl/midi_uart_rx_param_sampler.sv
// Line front end: two-flop synchroniser, bit-period counter and a three-sample
// majority voter centred on mid-bit.
module midi_uart_rx_param_sampler
    import midi_uart_rx_param_pkg::*;
#(
    parameter int CYCLES_PER_BIT = 320
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic clear,
    output logic rxs,
    output logic sample_strobe,
    output logic voted_bit,
    output logic bit_end
);
    localparam int M     = CYCLES_PER_BIT / 2;
    localparam int CNT_W = $clog2(CYCLES_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_EARLY = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(M);
    localparam logic [CNT_W-1:0] CNT_LATE  = CNT_W'(M + 1);

    logic             sync1_r;
    logic             sync2_r;
    logic [CNT_W-1:0] cnt_r;
    logic             samp_a_r;
    logic             samp_b_r;

    // Synchroniser idles high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
        end
    end

    // Bit-period counter and the two early samples of the vote.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= '0;
            samp_a_r <= 1'b1;
            samp_b_r <= 1'b1;
        end else begin
            if (clear || (cnt_r == CNT_LAST)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (cnt_r == CNT_EARLY) begin
                samp_a_r <= sync2_r;
            end
            if (cnt_r == CNT_MID) begin
                samp_b_r <= sync2_r;
            end
        end
    end

    assign rxs           = sync2_r;
    assign sample_strobe = (cnt_r == CNT_LATE);
    assign bit_end       = (cnt_r == CNT_LAST);
    assign voted_bit     = maj3(samp_a_r, samp_b_r, sync2_r);

endmodule

// File: rtl/midi_uart_rx_param.sv
// Parametrised MIDI UART receiver: frame FSM, shift register, parity/stop
// checking and a single-entry holding register behind a valid/ready handshake.
module midi_uart_rx_param
    import midi_uart_rx_param_pkg::*;
#(
    parameter int CLK_PERIOD_NS = DEFAULT_CLK_PERIOD_NS,
    parameter int BIT_RATE_HZ   = 31250,
    parameter int PAYLOAD_BITS  = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    rx_i,
    midi_uart_rx_param_if.master    bus
);
    localparam int  CYCLES_PER_BIT = (1_000_000_000 / BIT_RATE_HZ) / CLK_PERIOD_NS;
    localparam bit  HAS_PARITY     = (PARITY_MODE != PARITY_NONE);
    localparam logic [3:0] LAST_DATA = 4'(PAYLOAD_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    if (CYCLES_PER_BIT < 32'sd8) begin : g_bad_rate
        $error("midi_uart_rx_param: fewer than 8 clock cycles per bit");
    end
    if ((PAYLOAD_BITS < 32'sd5) || (PAYLOAD_BITS > 32'sd9)) begin : g_bad_width
        $error("midi_uart_rx_param: PAYLOAD_BITS must be 5..9");
    end
    if ((STOP_BITS < 32'sd1) || (STOP_BITS > 32'sd2)) begin : g_bad_stop
        $error("midi_uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if ((PARITY_MODE < 32'sd0) || (PARITY_MODE > 32'sd2)) begin : g_bad_parity
        $error("midi_uart_rx_param: PARITY_MODE must be 0, 1 or 2");
    end

    rx_state_e               state_r, state_n;
    logic                    rxs_s, strobe_s, voted_s, bit_end_s;
    logic                    clear_cnt_s, shift_s, cap_par_s, stop_lo_s;
    logic                    complete_s, bit_inc_s, bit_clr_s;
    logic                    frame_err_s, parity_err_s;
    logic [8:0]              word_ext_s;
    logic [PAYLOAD_BITS-1:0] shreg_r;
    logic [3:0]              bit_idx_r;
    logic                    par_bit_r;
    logic                    stop_err_r;
    logic [PAYLOAD_BITS-1:0] data_r;
    logic                    valid_r, frame_err_r, parity_err_r, overrun_r, busy_r;

    midi_uart_rx_param_sampler #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT)
    ) u_uart_rx_sampler (
        .clk           (clk_i),
        .rst           (rst_i),
        .rx            (rx_i),
        .clear         (clear_cnt_s),
        .rxs           (rxs_s),
        .sample_strobe (strobe_s),
        .voted_bit     (voted_s),
        .bit_end       (bit_end_s)
    );

    // Frame state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        state_n     = state_r;
        clear_cnt_s = 1'b0;
        shift_s     = 1'b0;
        cap_par_s   = 1'b0;
        stop_lo_s   = 1'b0;
        complete_s  = 1'b0;
        bit_inc_s   = 1'b0;
        bit_clr_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!rxs_s) begin
                    state_n     = S_START;
                    clear_cnt_s = 1'b1;
                    bit_clr_s   = 1'b1;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_START: begin
                if (strobe_s && voted_s) begin
                    state_n = S_IDLE;
                end else if (bit_end_s) begin
                    state_n = S_DATA;
                end else begin
                    state_n = S_START;
                end
            end
            S_DATA: begin
                shift_s = strobe_s;
                if (bit_end_s && (bit_idx_r == LAST_DATA)) begin
                    bit_clr_s = 1'b1;
                    state_n   = HAS_PARITY ? S_PARITY : S_STOP;
                end else if (bit_end_s) begin
                    bit_inc_s = 1'b1;
                end else begin
                    state_n = S_DATA;
                end
            end
            S_PARITY: begin
                cap_par_s = strobe_s;
                if (bit_end_s) begin
                    state_n = S_STOP;
                end else begin
                    state_n = S_PARITY;
                end
            end
            S_STOP: begin
                // The last stop bit completes on its vote, not at its wrap.
                if (strobe_s) begin
                    stop_lo_s = ~voted_s;
                    if (bit_idx_r == LAST_STOP) begin
                        complete_s = 1'b1;
                        bit_clr_s  = 1'b1;
                        state_n    = (stop_err_r || !voted_s) ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        state_n = S_STOP;
                    end
                end else if (bit_end_s) begin
                    bit_inc_s = 1'b1;
                end else begin
                    state_n = S_STOP;
                end
            end
            S_WAIT_HIGH: begin
                if (rxs_s) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_WAIT_HIGH;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Shift register, bit index, parity bit and sticky stop-bit error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_r    <= '0;
            bit_idx_r  <= 4'd0;
            par_bit_r  <= 1'b0;
            stop_err_r <= 1'b0;
        end else begin
            if (bit_clr_s) begin
                bit_idx_r <= 4'd0;
            end else if (bit_inc_s) begin
                bit_idx_r <= bit_idx_r + 4'd1;
            end
            if (shift_s) begin
                shreg_r <= {voted_s, shreg_r[PAYLOAD_BITS-1:1]};
            end
            if (cap_par_s) begin
                par_bit_r <= voted_s;
            end
            if (clear_cnt_s) begin
                stop_err_r <= 1'b0;
            end else if (stop_lo_s) begin
                stop_err_r <= 1'b1;
            end
        end
    end

    // Completion-cycle error flags.
    always_comb begin
        word_ext_s                   = 9'd0;
        word_ext_s[PAYLOAD_BITS-1:0] = shreg_r;
        frame_err_s                  = stop_err_r | ~voted_s;
        case (PARITY_MODE)
            PARITY_EVEN: parity_err_s = parity9(word_ext_s) ^ par_bit_r;
            PARITY_ODD:  parity_err_s = ~(parity9(word_ext_s) ^ par_bit_r);
            default:     parity_err_s = 1'b0;
        endcase
    end

    // Holding register: a frame arriving against a stalled word is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_r       <= '0;
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            busy_r    <= (state_n != S_IDLE);
            if (complete_s && (!valid_r || bus.ready_i)) begin
                data_r       <= shreg_r;
                frame_err_r  <= frame_err_s;
                parity_err_r <= parity_err_s;
                valid_r      <= 1'b1;
            end else if (complete_s) begin
                overrun_r <= 1'b1;
            end else if (valid_r && bus.ready_i) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign bus.data_o       = data_r;
    assign bus.valid_o      = valid_r;
    assign bus.frame_err_o  = frame_err_r;
    assign bus.parity_err_o = parity_err_r;
    assign bus.overrun_o    = overrun_r;
    assign bus.busy_o       = busy_r;

endmodule

// File: tb/tb_midi_uart_rx_param.sv
// Directed bench: an 8N1 receiver and an 8E1 receiver, each fed by its own line.
module tb_midi_uart_rx_param;
    localparam int CPB = 320;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int vcyc0    = 0;
    int ovr0     = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    midi_uart_rx_param_if #(.PAYLOAD_BITS(8)) bus0();
    midi_uart_rx_param_if #(.PAYLOAD_BITS(8)) bus1();

    midi_uart_rx_param #(
        .CLK_PERIOD_NS(100), .BIT_RATE_HZ(31250), .PAYLOAD_BITS(8),
        .PARITY_MODE(0), .STOP_BITS(1)
    ) dut0 (.clk_i(clk), .rst_i(rst), .rx_i(rx0), .bus(bus0));

    midi_uart_rx_param #(
        .CLK_PERIOD_NS(100), .BIT_RATE_HZ(31250), .PAYLOAD_BITS(8),
        .PARITY_MODE(1), .STOP_BITS(1)
    ) dut1 (.clk_i(clk), .rst_i(rst), .rx_i(rx1), .bus(bus1));

    always #50 clk = ~clk;

    // Record every accepted word as {parity_err, frame_err, data}.
    always @(negedge clk) begin
        if (bus0.valid_o && bus0.ready_i) q0.push_back({bus0.parity_err_o, bus0.frame_err_o, bus0.data_o});
        if (bus1.valid_o && bus1.ready_i) q1.push_back({bus1.parity_err_o, bus1.frame_err_o, bus1.data_o});
        if (bus0.valid_o) vcyc0++;
        if (bus0.overrun_o) ovr0++;
    end

    function automatic logic [15:0] frame8(input logic [7:0] d);
        return {6'd0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame8p(input logic [7:0] d, input logic p);
        return {5'd0, 1'b1, p, d, 1'b0};
    endfunction

    // Drives n bits LSB first, CPB cycles each; optional one-cycle low glitch.
    task automatic drive_bits(input int sel, input logic [15:0] bits, input int n,
                              input int gbit, input int goff);
        logic v;
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < CPB; c++) begin
                v = bits[k];
                if (k == gbit && c == goff) v = 1'b0;
                if (sel == 0) rx0 = v; else rx1 = v;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus0.data_o, bus0.valid_o, bus0.frame_err_o, bus0.parity_err_o, bus0.overrun_o, bus0.busy_o} !== 13'd0) begin
            $display("FAIL reset_dut0 got %h required 0", {bus0.data_o, bus0.valid_o, bus0.frame_err_o, bus0.parity_err_o, bus0.overrun_o, bus0.busy_o});
            n_fail++;
        end
        n_checks++;
        if ({bus1.data_o, bus1.valid_o, bus1.frame_err_o, bus1.parity_err_o, bus1.overrun_o, bus1.busy_o} !== 13'd0) begin
            $display("FAIL reset_dut1 got %h required 0", {bus1.data_o, bus1.valid_o, bus1.frame_err_o, bus1.parity_err_o, bus1.overrun_o, bus1.busy_o});
            n_fail++;
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus0.busy_o !== 1'b0) begin
            $display("FAIL idle_busy got %b required 0", bus0.busy_o);
            n_fail++;
        end
    endtask

    task automatic test_basic_8n1();
        int lat;
        logic [9:0] got;
        lat = -1;
        q0.delete();
        vcyc0 = 0;
        fork
            drive_bits(0, frame8(8'h90), 10, -1, 0);
            begin
                @(posedge clk);
                for (int i = 1; i <= 4000; i++) begin
                    @(posedge clk);
                    #1;
                    if (bus0.valid_o) begin
                        lat = i;
                        break;
                    end
                end
            end
        join
        repeat (CPB) @(negedge clk);
        n_checks++;
        if (lat !== 3044) begin
            $display("FAIL latency_8n1 got %0d required %0d", lat, 3044);
            n_fail++;
        end
        got = (q0.size() > 0) ? q0[0] : 10'h3FF;
        n_checks++;
        if (q0.size() != 1 || got !== {2'b00, 8'h90}) begin
            $display("FAIL word_0x90 got %h (count %0d) required %h (count 1)", got, q0.size(), {2'b00, 8'h90});
            n_fail++;
        end
        n_checks++;
        if (vcyc0 !== 1) begin
            $display("FAIL valid_width got %0d cycles required 1", vcyc0);
            n_fail++;
        end
    endtask

    task automatic test_parity();
        logic [9:0] got;
        q1.delete();
        drive_bits(1, frame8p(8'h3C, 1'b1), 11, -1, 0);
        repeat (CPB) @(negedge clk);
        drive_bits(1, frame8p(8'h3C, 1'b0), 11, -1, 0);
        repeat (CPB) @(negedge clk);
        drive_bits(1, frame8p(8'h07, 1'b1), 11, -1, 0);
        repeat (CPB) @(negedge clk);
        n_checks++;
        if (q1.size() != 3) begin
            $display("FAIL parity_count got %0d required 3", q1.size());
            n_fail++;
        end
        got = (q1.size() > 0) ? q1[0] : 10'h000;
        n_checks++;
        if (got !== {2'b10, 8'h3C}) begin
            $display("FAIL parity_bad got %h required %h", got, {2'b10, 8'h3C});
            n_fail++;
        end
        got = (q1.size() > 1) ? q1[1] : 10'h3FF;
        n_checks++;
        if (got !== {2'b00, 8'h3C}) begin
            $display("FAIL parity_good got %h required %h", got, {2'b00, 8'h3C});
            n_fail++;
        end
        got = (q1.size() > 2) ? q1[2] : 10'h3FF;
        n_checks++;
        if (got !== {2'b00, 8'h07}) begin
            $display("FAIL parity_odd_weight got %h required %h", got, {2'b00, 8'h07});
            n_fail++;
        end
    endtask

    task automatic test_false_start();
        logic [9:0] got;
        q0.delete();
        rx0 = 1'b0;
        repeat (50) @(negedge clk);
        n_checks++;
        if (bus0.busy_o !== 1'b1) begin
            $display("FAIL false_start_busy got %b required 1", bus0.busy_o);
            n_fail++;
        end
        repeat (50) @(negedge clk);
        rx0 = 1'b1;
        repeat (100) @(negedge clk);
        n_checks++;
        if (bus0.busy_o !== 1'b0) begin
            $display("FAIL false_start_idle got %b required 0", bus0.busy_o);
            n_fail++;
        end
        repeat (12 * CPB) @(negedge clk);
        n_checks++;
        if (q0.size() != 0) begin
            $display("FAIL false_start_words got %0d required 0", q0.size());
            n_fail++;
        end
        drive_bits(0, frame8(8'h45), 10, -1, 0);
        repeat (CPB) @(negedge clk);
        got = (q0.size() > 0) ? q0[0] : 10'h3FF;
        n_checks++;
        if (q0.size() != 1 || got !== {2'b00, 8'h45}) begin
            $display("FAIL after_false_start got %h (count %0d) required %h", got, q0.size(), {2'b00, 8'h45});
            n_fail++;
        end
    endtask

    task automatic test_break();
        logic [9:0] got;
        q0.delete();
        rx0 = 1'b0;
        repeat (15 * CPB) @(negedge clk);
        got = (q0.size() > 0) ? q0[0] : 10'h3FF;
        n_checks++;
        if (q0.size() != 1 || got !== {2'b01, 8'h00}) begin
            $display("FAIL break_word got %h (count %0d) required %h (count 1)", got, q0.size(), {2'b01, 8'h00});
            n_fail++;
        end
        n_checks++;
        if (bus0.busy_o !== 1'b1) begin
            $display("FAIL break_wait_high got %b required 1", bus0.busy_o);
            n_fail++;
        end
        rx0 = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        n_checks++;
        if (q0.size() != 1 || bus0.busy_o !== 1'b0) begin
            $display("FAIL break_release got count %0d busy %b required count 1 busy 0", q0.size(), bus0.busy_o);
            n_fail++;
        end
        drive_bits(0, frame8(8'hF8), 10, -1, 0);
        repeat (CPB) @(negedge clk);
        got = (q0.size() > 1) ? q0[1] : 10'h3FF;
        n_checks++;
        if (got !== {2'b00, 8'hF8}) begin
            $display("FAIL after_break got %h required %h", got, {2'b00, 8'hF8});
            n_fail++;
        end
    endtask

    task automatic test_overrun();
        logic [9:0] got;
        q0.delete();
        ovr0 = 0;
        bus0.ready_i = 1'b0;
        drive_bits(0, frame8(8'h80), 10, -1, 0);
        repeat (CPB) @(negedge clk);
        drive_bits(0, frame8(8'h40), 10, -1, 0);
        repeat (CPB) @(negedge clk);
        n_checks++;
        if (ovr0 !== 1) begin
            $display("FAIL overrun_pulses got %0d required 1", ovr0);
            n_fail++;
        end
        n_checks++;
        if ({bus0.valid_o, bus0.frame_err_o, bus0.data_o} !== {2'b10, 8'h80}) begin
            $display("FAIL overrun_hold got %h required %h", {bus0.valid_o, bus0.frame_err_o, bus0.data_o}, {2'b10, 8'h80});
            n_fail++;
        end
        @(posedge clk);
        #1 bus0.ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        got = (q0.size() > 0) ? q0[0] : 10'h3FF;
        n_checks++;
        if (bus0.valid_o !== 1'b0 || q0.size() != 1 || got !== {2'b00, 8'h80}) begin
            $display("FAIL overrun_drain got valid %b word %h count %0d required valid 0 word %h count 1", bus0.valid_o, got, q0.size(), {2'b00, 8'h80});
            n_fail++;
        end
    endtask

    task automatic test_glitch();
        logic [9:0] got;
        q0.delete();
        drive_bits(0, frame8(8'hFF), 10, 2, 161);
        repeat (CPB) @(negedge clk);
        got = (q0.size() > 0) ? q0[0] : 10'h3FF;
        n_checks++;
        if (q0.size() != 1 || got !== {2'b00, 8'hFF}) begin
            $display("FAIL glitch_vote got %h (count %0d) required %h", got, q0.size(), {2'b00, 8'hFF});
            n_fail++;
        end
    endtask

    task automatic test_reset_midframe();
        q0.delete();
        rx0 = 1'b0;
        repeat (1000) @(negedge clk);
        n_checks++;
        if (bus0.busy_o !== 1'b1) begin
            $display("FAIL midframe_busy got %b required 1", bus0.busy_o);
            n_fail++;
        end
        #10 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus0.data_o, bus0.valid_o, bus0.frame_err_o, bus0.parity_err_o, bus0.overrun_o, bus0.busy_o} !== 13'd0) begin
            $display("FAIL async_reset got %h required 0", {bus0.data_o, bus0.valid_o, bus0.frame_err_o, bus0.parity_err_o, bus0.overrun_o, bus0.busy_o});
            n_fail++;
        end
        rx0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        n_checks++;
        if (bus0.busy_o !== 1'b0 || q0.size() != 0) begin
            $display("FAIL post_reset got busy %b count %0d required busy 0 count 0", bus0.busy_o, q0.size());
            n_fail++;
        end
    endtask

    initial begin
        bus0.ready_i = 1'b1;
        bus1.ready_i = 1'b1;
        test_reset();
        test_basic_8n1();
        test_parity();
        test_false_start();
        test_break();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #15_000_000;
        $display("FAIL watchdog expired before the sequence completed");
        $fatal(1, "watchdog");
    end
endmodule
